accumulator_mem_arbiter: RTL and testbench

Round-robin arbiter that shares the single accumulator memory port (op/signal/read/write) among NUM_ADDERS adder units. Each adder posts a FETCH (get operand) or SEND (return result) request. The arbiter serialises these requests onto the memory port, returns fetched data, and acknowledges completion. It sits between the adder array and accumulator_memory, and owns the memory op bus once loading is complete.

---
 rtl/accumulator_mem_arbiter.sv | 142 ++++++++++++++
 tb/tb_accumulator_mem_arbiter.sv | 342 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/accumulator_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : accumulator_mem_arbiter
// Brief    : Round-robin arbiter serialising adder FETCH/SEND requests onto
//            the single accumulator memory port, with a watchdog.
// Revision : 1.0 - initial release
// ============================================================================
module accumulator_mem_arbiter #(
  parameter int NUM_ADDERS = 4,
  parameter int IDX_W      = 2,
  parameter int TIMEOUT    = 64
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [2*NUM_ADDERS-1:0]  i_req_op,
  input  logic [32*NUM_ADDERS-1:0] i_req_data,
  output logic [NUM_ADDERS-1:0]    o_ack,
  output logic [31:0]              o_rd_data,
  output logic [IDX_W-1:0]         o_owner,
  output logic [1:0]               o_mem_op,
  output logic [31:0]              o_mem_write,
  input  logic                     i_mem_signal,
  input  logic [31:0]              i_mem_read,
  output logic                     o_err,
  output logic [2:0]               o_state
);

  localparam logic [1:0] c_OP_NOP   = 2'b00;
  localparam logic [1:0] c_OP_FETCH = 2'b01;
  localparam logic [1:0] c_OP_SEND  = 2'b10;
  localparam int c_CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'b001,
    S_BUSY    = 3'b010,
    S_RELEASE = 3'b100
  } state_t;

  state_t             r_state;
  logic [IDX_W-1:0]   r_rr_ptr;
  logic [c_CNT_W-1:0] r_wdog;

  logic [1:0]            w_op   [NUM_ADDERS];
  logic [31:0]           w_data [NUM_ADDERS];
  logic [NUM_ADDERS-1:0] w_valid;
  logic [NUM_ADDERS-1:0] w_owner_hot;

  generate
    for (genvar g = 0; g < NUM_ADDERS; g++) begin : g_split
      assign w_op[g]        = i_req_op[2*g +: 2];
      assign w_data[g]      = i_req_data[32*g +: 32];
      assign w_valid[g]     = (w_op[g] == c_OP_FETCH) || (w_op[g] == c_OP_SEND);
      assign w_owner_hot[g] = (o_owner == IDX_W'(g));
    end
  endgenerate

  // Winner is the valid requester with the smallest circular distance from rr_ptr.
  logic             w_any;
  logic [IDX_W-1:0] w_sel;
  logic [1:0]       w_sel_op;
  logic [31:0]      w_sel_data;

  always_comb begin
    int v_best;
    int v_dist;
    w_any      = 1'b0;
    w_sel      = '0;
    w_sel_op   = c_OP_NOP;
    w_sel_data = '0;
    v_best     = NUM_ADDERS;
    v_dist     = 0;
    for (int j = 0; j < NUM_ADDERS; j++) begin
      v_dist = j - int'(r_rr_ptr);
      if (v_dist < 0) v_dist = v_dist + NUM_ADDERS;
      if (w_valid[j] && (v_dist < v_best)) begin
        v_best     = v_dist;
        w_any      = 1'b1;
        w_sel      = IDX_W'(j);
        w_sel_op   = w_op[j];
        w_sel_data = w_data[j];
      end
    end
  end

  logic [IDX_W-1:0] w_rr_next;
  logic             w_done;

  assign w_rr_next = (o_owner == IDX_W'(NUM_ADDERS - 1)) ? '0 : o_owner + 1'b1;
  assign w_done    = i_mem_signal || (r_wdog == c_CNT_LAST);
  assign o_state   = r_state;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_rr_ptr    <= '0;
      r_wdog      <= '0;
      o_ack       <= '0;
      o_rd_data   <= '0;
      o_owner     <= '0;
      o_mem_op    <= c_OP_NOP;
      o_mem_write <= '0;
      o_err       <= 1'b0;
    end else begin
      o_ack <= '0;
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            o_owner     <= w_sel;
            o_mem_op    <= w_sel_op;
            o_mem_write <= (w_sel_op == c_OP_SEND) ? w_sel_data : 32'd0;
            r_wdog      <= '0;
            r_state     <= S_BUSY;
          end
        end
        S_BUSY: begin
          if (w_done) begin
            o_ack <= w_owner_hot;
            // A real completion wins over a watchdog expiry in the same cycle.
            if (i_mem_signal) begin
              if (o_mem_op == c_OP_FETCH) o_rd_data <= i_mem_read;
            end else begin
              o_rd_data <= '0;
              o_err     <= 1'b1;
            end
            o_mem_op    <= c_OP_NOP;
            o_mem_write <= '0;
            r_rr_ptr    <= w_rr_next;
            r_wdog      <= '0;
            r_state     <= S_RELEASE;
          end else begin
            r_wdog <= r_wdog + 1'b1;
          end
        end
        S_RELEASE: r_state <= S_IDLE;
        default:   r_state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_accumulator_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_accumulator_mem_arbiter
// Brief    : Self-checking bench with a transaction-level arbiter model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_accumulator_mem_arbiter;

  localparam int N   = 4;
  localparam int TMO = 8;

  logic         clk = 1'b0;
  logic         reset;
  logic [7:0]   req_op;
  logic [127:0] req_data;
  logic [3:0]   ack;
  logic [31:0]  rd_data;
  logic [1:0]   owner;
  logic [1:0]   mem_op;
  logic [31:0]  mem_write;
  logic         mem_signal;
  logic [31:0]  mem_read;
  logic         err;
  logic [2:0]   state;

  accumulator_mem_arbiter #(.NUM_ADDERS(N), .IDX_W(2), .TIMEOUT(TMO)) dut (
    .clk(clk), .reset(reset), .i_req_op(req_op), .i_req_data(req_data),
    .o_ack(ack), .o_rd_data(rd_data), .o_owner(owner), .o_mem_op(mem_op),
    .o_mem_write(mem_write), .i_mem_signal(mem_signal), .i_mem_read(mem_read),
    .o_err(err), .o_state(state)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  int          m_rr;
  logic [31:0] m_rd;
  logic        m_err;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [1:0] op_of(input logic [7:0] ops, input int i);
    return 2'((ops >> (2*i)) & 8'h3);
  endfunction

  function automatic logic [31:0] data_of(input logic [127:0] d, input int i);
    return 32'(d >> (32*i));
  endfunction

  function automatic int pick(input logic [7:0] ops, input int rr);
    int i;
    logic [1:0] o;
    for (int k = 0; k < N; k++) begin
      i = (rr + k) % N;
      o = op_of(ops, i);
      if (o == 2'b01 || o == 2'b10) return i;
    end
    return -1;
  endfunction

  task automatic test_reset();
    reset = 1'b1; mem_signal = 1'b0; mem_read = $urandom;
    req_op = 8'($urandom); req_data = {$urandom, $urandom, $urandom, $urandom};
    tick(); tick();
    tests++;
    if (ack !== 4'd0 || rd_data !== 32'd0 || owner !== 2'd0 || err !== 1'b0) begin
      fails++;
      $display("FAIL reset_outputs: ack=%h rd=%h owner=%0d err=%b, required 0/0/0/0", ack, rd_data, owner, err);
    end
    tests++;
    if (state !== 3'b001 || mem_op !== 2'b00 || mem_write !== 32'd0) begin
      fails++;
      $display("FAIL reset_state: state=%b mem_op=%b mem_write=%h, required 001/00/0", state, mem_op, mem_write);
    end
    reset = 1'b0; req_op = 8'h00;
    m_rr = 0; m_rd = 32'd0; m_err = 1'b0;
    tick();
    tests++;
    if (state !== 3'b001 || mem_op !== 2'b00) begin
      fails++;
      $display("FAIL idle_no_req: state=%b mem_op=%b, required 001/00", state, mem_op);
    end
  endtask

  task automatic test_single_fetch();
    req_op = 8'h10;
    tick();
    tests++;
    if (state !== 3'b010 || mem_op !== 2'b01 || owner !== 2'd2 || mem_write !== 32'd0) begin
      fails++;
      $display("FAIL fetch_grant: state=%b op=%b owner=%0d wr=%h, required 010/01/2/0", state, mem_op, owner, mem_write);
    end
    for (int c = 0; c < 3; c++) begin
      tick();
      tests++;
      if (ack !== 4'd0 || mem_op !== 2'b01 || state !== 3'b010) begin
        fails++;
        $display("FAIL fetch_wait: ack=%b op=%b state=%b, required 0000/01/010", ack, mem_op, state);
      end
    end
    mem_signal = 1'b1; mem_read = 32'h0000BEEF;
    tick();
    mem_signal = 1'b0; mem_read = 32'hDEAD0000;
    tests++;
    if (ack !== 4'b0100 || rd_data !== 32'h0000BEEF || mem_op !== 2'b00 || state !== 3'b100) begin
      fails++;
      $display("FAIL fetch_ack: ack=%b rd=%h op=%b state=%b, required 0100/0000beef/00/100", ack, rd_data, mem_op, state);
    end
    req_op = 8'h00;
    tick();
    tests++;
    if (ack !== 4'd0 || state !== 3'b001 || rd_data !== 32'h0000BEEF) begin
      fails++;
      $display("FAIL fetch_release: ack=%b state=%b rd=%h, required 0000/001/0000beef", ack, state, rd_data);
    end
    m_rr = 3; m_rd = 32'h0000BEEF;
  endtask

  task automatic test_round_robin();
    int exp;
    logic [31:0] d;
    reset = 1'b1; tick(); reset = 1'b0;
    m_rr = 0; m_rd = 32'd0; m_err = 1'b0;
    req_op = 8'h55;
    for (int k = 0; k < 5; k++) begin
      exp = pick(req_op, m_rr);
      tick();
      tests++;
      if (owner !== 2'(exp) || exp != (k % N) || state !== 3'b010) begin
        fails++;
        $display("FAIL rr_grant%0d: owner=%0d state=%b, required %0d/010", k, owner, state, k % N);
      end
      d = $urandom; mem_signal = 1'b1; mem_read = d;
      tick();
      mem_signal = 1'b0;
      m_rd = d; m_rr = (exp + 1) % N;
      tests++;
      if (ack !== 4'(1 << exp) || rd_data !== m_rd) begin
        fails++;
        $display("FAIL rr_ack%0d: ack=%b rd=%h, required %b/%h", k, ack, rd_data, 4'(1 << exp), m_rd);
      end
      if (k == 4) req_op = 8'h00;
      tick();
    end
  endtask

  task automatic test_send();
    logic [31:0] prev;
    prev = m_rd;
    req_op = 8'h80; req_data = {32'h12345678, 96'd0};
    tick();
    tests++;
    if (owner !== 2'd3 || mem_op !== 2'b10 || mem_write !== 32'h12345678) begin
      fails++;
      $display("FAIL send_grant: owner=%0d op=%b wr=%h, required 3/10/12345678", owner, mem_op, mem_write);
    end
    for (int c = 0; c < 2; c++) begin
      tick();
      tests++;
      if (mem_op !== 2'b10 || mem_write !== 32'h12345678 || ack !== 4'd0) begin
        fails++;
        $display("FAIL send_hold: op=%b wr=%h ack=%b, required 10/12345678/0000", mem_op, mem_write, ack);
      end
    end
    mem_signal = 1'b1; mem_read = 32'hCAFEF00D;
    tick();
    mem_signal = 1'b0;
    tests++;
    if (ack !== 4'b1000 || rd_data !== prev || mem_op !== 2'b00) begin
      fails++;
      $display("FAIL send_ack: ack=%b rd=%h op=%b, required 1000/%h/00", ack, rd_data, mem_op, prev);
    end
    req_op = 8'h00;
    tick();
    m_rr = 0;
  endtask

  task automatic test_watchdog();
    logic [31:0] d;
    req_op = 8'h01;
    tick();
    for (int c = 1; c < TMO; c++) begin
      tick();
      tests++;
      if (ack !== 4'd0 || state !== 3'b010 || err !== 1'b0) begin
        fails++;
        $display("FAIL wdog_wait%0d: ack=%b state=%b err=%b, required 0000/010/0", c, ack, state, err);
      end
    end
    tick();
    tests++;
    if (ack !== 4'b0001 || rd_data !== 32'd0 || err !== 1'b1 || state !== 3'b100 || mem_op !== 2'b00) begin
      fails++;
      $display("FAIL wdog_fire: ack=%b rd=%h err=%b state=%b op=%b, required 0001/0/1/100/00", ack, rd_data, err, state, mem_op);
    end
    m_rd = 32'd0; m_err = 1'b1; m_rr = 1;
    req_op = 8'h00;
    tick();
    req_op = 8'h04;
    tick();
    tests++;
    if (owner !== 2'd1 || mem_op !== 2'b01 || err !== 1'b1) begin
      fails++;
      $display("FAIL wdog_next_grant: owner=%0d op=%b err=%b, required 1/01/1", owner, mem_op, err);
    end
    d = $urandom; mem_signal = 1'b1; mem_read = d;
    tick();
    mem_signal = 1'b0;
    tests++;
    if (ack !== 4'b0010 || rd_data !== d || err !== 1'b1) begin
      fails++;
      $display("FAIL wdog_next_ack: ack=%b rd=%h err=%b, required 0010/%h/1", ack, rd_data, err, d);
    end
    m_rd = d; m_rr = 2;
    req_op = 8'h00;
    tick();
  endtask

  task automatic test_reset_mid_busy();
    req_op = 8'h10;
    tick(); tick();
    reset = 1'b1; mem_signal = 1'b1; mem_read = $urandom;
    tick();
    tests++;
    if (mem_op !== 2'b00 || ack !== 4'd0 || state !== 3'b001 || err !== 1'b0) begin
      fails++;
      $display("FAIL reset_busy: op=%b ack=%b state=%b err=%b, required 00/0000/001/0", mem_op, ack, state, err);
    end
    reset = 1'b0; mem_signal = 1'b0;
    m_rr = 0; m_rd = 32'd0; m_err = 1'b0;
    req_op = 8'h55;
    tick();
    tests++;
    if (owner !== 2'd0 || state !== 3'b010) begin
      fails++;
      $display("FAIL reset_rr_ptr: owner=%0d state=%b, required 0/010", owner, state);
    end
    mem_signal = 1'b1; mem_read = 32'h0BADF00D;
    tick();
    mem_signal = 1'b0; m_rd = 32'h0BADF00D; m_rr = 1;
    req_op = 8'h00;
    tick();
  endtask

  task automatic test_random();
    int exp, lat;
    bit tmo;
    logic [1:0] eop;
    logic [31:0] ewr, d;
    req_op = 8'($urandom); req_data = {$urandom, $urandom, $urandom, $urandom};
    for (int t = 0; t < 60; t++) begin
      exp = pick(req_op, m_rr);
      mem_signal = 1'($urandom); mem_read = $urandom;
      tick();
      mem_signal = 1'b0;
      if (exp < 0) begin
        tests++;
        if (state !== 3'b001 || mem_op !== 2'b00 || ack !== 4'd0) begin
          fails++;
          $display("FAIL rnd_idle%0d: state=%b op=%b ack=%b, required 001/00/0000", t, state, mem_op, ack);
        end
        req_op = 8'($urandom);
        continue;
      end
      eop = op_of(req_op, exp);
      ewr = (eop == 2'b10) ? data_of(req_data, exp) : 32'd0;
      tests++;
      if (owner !== 2'(exp) || mem_op !== eop || mem_write !== ewr || state !== 3'b010) begin
        fails++;
        $display("FAIL rnd_grant%0d: owner=%0d op=%b wr=%h state=%b, required %0d/%b/%h/010", t, owner, mem_op, mem_write, state, exp, eop, ewr);
      end
      lat = $urandom_range(0, 9);
      tmo = 1'b0; d = 32'd0;
      for (int b = 1; b <= TMO; b++) begin
        if (b - 1 == lat) begin
          d = $urandom; mem_signal = 1'b1; mem_read = d;
          tick();
          mem_signal = 1'b0;
          break;
        end else if (b == TMO) begin
          mem_read = $urandom;
          tick();
          tmo = 1'b1;
          break;
        end
        tick();
        tests++;
        if (ack !== 4'd0 || state !== 3'b010 || mem_op !== eop || mem_write !== ewr) begin
          fails++;
          $display("FAIL rnd_busy%0d: ack=%b state=%b op=%b wr=%h, required 0000/010/%b/%h", t, ack, state, mem_op, mem_write, eop, ewr);
        end
      end
      if (tmo) begin
        m_rd = 32'd0; m_err = 1'b1;
      end else if (eop == 2'b01) begin
        m_rd = d;
      end
      m_rr = (exp + 1) % N;
      tests++;
      if (ack !== 4'(1 << exp) || rd_data !== m_rd || err !== m_err || state !== 3'b100 || mem_op !== 2'b00) begin
        fails++;
        $display("FAIL rnd_done%0d: ack=%b rd=%h err=%b state=%b op=%b, required %b/%h/%b/100/00", t, ack, rd_data, err, state, mem_op, 4'(1 << exp), m_rd, m_err);
      end
      req_op   = (req_op & ~(8'h3 << (2*exp))) | (8'(2'($urandom)) << (2*exp));
      req_data = (req_data & ~(128'hFFFFFFFF << (32*exp))) | (128'($urandom) << (32*exp));
      mem_signal = 1'($urandom); mem_read = $urandom;
      tick();
      mem_signal = 1'b0;
      tests++;
      if (state !== 3'b001 || ack !== 4'd0) begin
        fails++;
        $display("FAIL rnd_release%0d: state=%b ack=%b, required 001/0000", t, state, ack);
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not complete, required completion");
    $fatal(1, "bench timeout");
  end

  initial begin
    reset = 1'b1; req_op = 8'h00; req_data = '0; mem_signal = 1'b0; mem_read = '0;
    test_reset();
    test_single_fetch();
    test_round_robin();
    test_send();
    test_watchdog();
    test_reset_mid_busy();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
